// File: rtl/spart_send_queue_pkg.sv
// Shared definitions for the SPART send path: drain FSM encoding,
// SPART register addresses and the default queue depth.
package spart_send_queue_pkg;

  localparam int DEFAULT_DEPTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [2:0] SPART_ADDR_TX      = 3'h0;
  localparam logic [2:0] SPART_ADDR_STATUS  = 3'h1;
  localparam logic [2:0] SPART_ADDR_BAUD_LO = 3'h2;
  localparam logic [2:0] SPART_ADDR_BAUD_HI = 3'h3;

  // A write is followed by one idle cycle before the next pop can be considered.
  function automatic logic [1:0] drain_next(input logic [1:0] st, input logic start);
    case (st)
      ST_IDLE:  drain_next = start ? ST_WRITE : ST_IDLE;
      ST_WRITE: drain_next = ST_GAP;
      default:  drain_next = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer, occupancy and full/empty bookkeeping for a power-of-two circular buffer.
module sync_fifo_ptr
  import spart_send_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req,
  input  logic                       pop,
  output logic                       push,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Flags come from the registered count only, so a pop never frees room
  // for a push on the same edge.
  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  assign push   = push_req && !full;
  assign wr_ptr = wr_ptr_reg;
  assign rd_ptr = rd_ptr_reg;
  assign count  = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spart_send_queue.sv
// Queues EX-stage SPART send requests and drains them as single-cycle
// register writes, at most one every three cycles.
module spart_send_queue
  import spart_send_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     send,
  input  logic [2:0]               spart_addr,
  input  logic [DATA_W-1:0]        send_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     tx_ready,
  output logic                     tx_wr,
  output logic [2:0]               tx_addr,
  output logic [DATA_W-1:0]        tx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 3;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [2:0]        tx_addr_reg;
  logic [DATA_W-1:0] tx_data_reg;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (send),
    .pop      (pop),
    .push     (push),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign pop        = (state_reg == ST_IDLE) && !empty && tx_ready;
  assign state_next = drain_next(state_reg, pop);
  // Decoded from the state register so reset drops the strobe immediately.
  assign tx_wr      = (state_reg == ST_WRITE);
  assign tx_addr    = tx_addr_reg;
  assign tx_data    = tx_data_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {spart_addr, send_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      tx_addr_reg <= SPART_ADDR_TX;
      tx_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) {tx_addr_reg, tx_data_reg} <= mem[rd_ptr];
    end
  end

endmodule
